// File: rtl/fifo_sync_if.sv
// Handshake bundle for fifo_sync: write side, read side, flush and status.
// The producer/consumer drives through master; the FIFO itself binds to slave.
interface fifo_sync_if #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 1024
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  clear;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  full;
  logic                  almost_full;
  logic                  overflow;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  empty;
  logic                  almost_empty;
  logic                  underflow;
  logic [CW-1:0]         count;

  modport master (
    output clear, wr_en, din, rd_en,
    input  full, almost_full, overflow, dout, empty, almost_empty, underflow, count
  );

  modport slave (
    input  clear, wr_en, din, rd_en,
    output full, almost_full, overflow, dout, empty, almost_empty, underflow, count
  );
endinterface

// File: rtl/fifo_sync.sv
// Single-clock FIFO of arbitrary depth with standard or first-word-fall-through read,
// occupancy count, programmable almost flags, sticky overflow/underflow and synchronous flush.
module fifo_sync #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 1024,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 4,
  parameter int AE_THRESH  = 4
) (
  input  logic        clock,
  input  logic        reset,
  fifo_sync_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit IsFwft = (FWFT != 0);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  out_vld_q, out_vld_d;

  logic                  full, empty;
  logic                  wr_acc, rd_acc;
  logic [CW-1:0]         ram_cnt;
  logic                  ram_rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // In FWFT mode the output register counts as one slot of occupancy; empty tracks
  // whether that slot holds a word, so a fresh write shows up one edge later.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = IsFwft ? !out_vld_q : (count_q == '0);
  assign wr_acc  = bus.wr_en && !full && !bus.clear;
  assign rd_acc  = bus.rd_en && !empty && !bus.clear;
  assign ram_cnt = count_q - CW'(out_vld_q);
  assign ram_rd  = IsFwft ? ((ram_cnt != '0) && (!out_vld_q || rd_acc) && !bus.clear)
                          : rd_acc;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dout_d    = dout_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    out_vld_d = out_vld_q;

    if (bus.clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
      out_vld_d = 1'b0;
    end else begin
      if (bus.wr_en && full) begin
        ovf_d = 1'b1;
      end
      if (bus.rd_en && empty) begin
        udf_d = 1'b1;
      end
      if (wr_acc) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (ram_rd) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        dout_d   = mem_q[rd_ptr_q];
      end
      if (IsFwft) begin
        if (ram_rd) begin
          out_vld_d = 1'b1;
        end else if (rd_acc) begin
          out_vld_d = 1'b0;
        end
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dout_q    <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dout_q    <= dout_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      out_vld_q <= out_vld_d;
    end
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_acc && !reset) begin
      mem_q[wr_ptr_q] <= bus.din;
    end
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (int'(count_q) >= AF_THRESH);
  assign bus.almost_empty = (int'(count_q) <= AE_THRESH);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
  assign bus.dout         = dout_q;
  assign bus.count        = count_q;

  a_count_bound: assert property (@(posedge clock) disable iff (reset)
    count_q <= CW'(DEPTH));
  a_out_stage_counted: assert property (@(posedge clock) disable iff (reset)
    out_vld_q |-> (count_q != '0));

endmodule

// File: tb/tb_fifo_sync.sv
// Drives a standard-read and an FWFT instance with identical stimulus and compares both
// against queue-based reference models.
module tb_fifo_sync;
  localparam int DW    = 24;
  localparam int DEPTH = 6;
  localparam int AF    = 5;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          wr  = 1'b0;
  logic          rd  = 1'b0;
  logic [DW-1:0] din = '0;

  always #5 clk = ~clk;

  fifo_sync_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus0 ();
  fifo_sync_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus1 ();

  assign bus0.clear = clr;
  assign bus0.wr_en = wr;
  assign bus0.din   = din;
  assign bus0.rd_en = rd;
  assign bus1.clear = clr;
  assign bus1.wr_en = wr;
  assign bus1.din   = din;
  assign bus1.rd_en = rd;

  fifo_sync #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)
  ) u_std (
    .clock(clk),
    .reset(rst),
    .bus  (bus0)
  );

  fifo_sync #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)
  ) u_fwft (
    .clock(clk),
    .reset(rst),
    .bus  (bus1)
  );

  logic [31:0] o_count [2];
  logic [31:0] o_dout  [2];
  logic        o_full  [2];
  logic        o_empty [2];
  logic        o_af    [2];
  logic        o_ae    [2];
  logic        o_ovf   [2];
  logic        o_udf   [2];

  assign o_count[0] = 32'(bus0.count);
  assign o_dout[0]  = 32'(bus0.dout);
  assign o_full[0]  = bus0.full;
  assign o_empty[0] = bus0.empty;
  assign o_af[0]    = bus0.almost_full;
  assign o_ae[0]    = bus0.almost_empty;
  assign o_ovf[0]   = bus0.overflow;
  assign o_udf[0]   = bus0.underflow;
  assign o_count[1] = 32'(bus1.count);
  assign o_dout[1]  = 32'(bus1.dout);
  assign o_full[1]  = bus1.full;
  assign o_empty[1] = bus1.empty;
  assign o_af[1]    = bus1.almost_full;
  assign o_ae[1]    = bus1.almost_empty;
  assign o_ovf[1]   = bus1.overflow;
  assign o_udf[1]   = bus1.underflow;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;

  // Model: queue of words plus the edge index each was written at.
  logic [DW-1:0] mq_d [2][$];
  int            mq_s [2][$];
  logic          m_ovf  [2];
  logic          m_udf  [2];
  logic [DW-1:0] m_dout [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // FWFT: a word becomes visible on the edge after the one that wrote it.
  function automatic bit m_empty(input int m);
    if (mq_d[m].size() == 0) return 1'b1;
    if (m == 1) return (mq_s[m][0] >= edge_n);
    return 1'b0;
  endfunction

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        mq_d[m].delete();
        mq_s[m].delete();
        m_ovf[m]  = 1'b0;
        m_udf[m]  = 1'b0;
        m_dout[m] = '0;
      end else if (clr) begin
        mq_d[m].delete();
        mq_s[m].delete();
        m_ovf[m] = 1'b0;
        m_udf[m] = 1'b0;
      end else begin
        bit is_full;
        bit is_empty;
        is_full  = (mq_d[m].size() == DEPTH);
        is_empty = m_empty(m);
        if (wr && is_full) m_ovf[m] = 1'b1;
        if (rd && is_empty) m_udf[m] = 1'b1;
        if (rd && !is_empty) begin
          logic [DW-1:0] w;
          w = mq_d[m].pop_front();
          void'(mq_s[m].pop_front());
          if (m == 0) m_dout[m] = w;
        end
        if (wr && !is_full) begin
          mq_d[m].push_back(din);
          mq_s[m].push_back(edge_n + 1);
        end
      end
    end
    edge_n++;
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      int sz;
      bit emp;
      sz  = mq_d[m].size();
      emp = m_empty(m);
      check($sformatf("m%0d count", m), o_count[m], 32'(sz));
      check($sformatf("m%0d full", m), 32'(o_full[m]), 32'(sz == DEPTH));
      check($sformatf("m%0d empty", m), 32'(o_empty[m]), 32'(emp));
      check($sformatf("m%0d almost_full", m), 32'(o_af[m]), 32'(sz >= AF));
      check($sformatf("m%0d almost_empty", m), 32'(o_ae[m]), 32'(sz <= AE));
      check($sformatf("m%0d overflow", m), 32'(o_ovf[m]), 32'(m_ovf[m]));
      check($sformatf("m%0d underflow", m), 32'(o_udf[m]), 32'(m_udf[m]));
      if (m == 0) begin
        check("m0 dout", o_dout[0], 32'(m_dout[0]));
      end else if (!emp) begin
        check("m1 dout", o_dout[1], 32'(mq_d[1][0]));
      end
    end
  endtask

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic c, input logic rs);
    wr  = w;
    din = d;
    rd  = r;
    clr = c;
    rst = rs;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    @(negedge clk);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Fall-through of a single word, then pop back to empty.
    step(1'b1, 24'hABCDEF, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Fill past full, drain past empty, refill across the pointer wrap.
    for (int i = 1; i <= 7; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 7; i <= 12; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Steady concurrent write+read at count 3.
    for (int i = 1; i <= 3; i++) step(1'b1, DW'(40 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, DW'(100 + i), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Concurrent write+read at full and at empty.
    for (int i = 0; i < 6; i++) step(1'b1, DW'(200 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 24'h000077, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 24'h000088, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Clear with a write pending, at count 4 with overflow set.
    for (int i = 0; i < 7; i++) step(1'b1, DW'(300 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 24'h000055, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Random traffic with varying rates, sparse clear and reset.
    for (int blk = 0; blk < 10; blk++) begin
      int pw;
      int pr;
      pw = int'($urandom_range(10, 90));
      pr = int'($urandom_range(10, 90));
      for (int i = 0; i < 200; i++) begin
        step(int'($urandom_range(0, 99)) < pw, DW'($urandom),
             int'($urandom_range(0, 99)) < pr,
             $urandom_range(0, 63) == 0, $urandom_range(0, 255) == 0);
      end
    end

    // Reset in the middle of traffic.
    for (int i = 0; i < 4; i++) step(1'b1, DW'(500 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 24'h0000AA, 1'b1, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
